sha256_msg_padder: RTL and testbench

Upstream feeder for the SHA-256 compression core. It accepts a message as a stream of big-endian 32-bit words with a valid/ready handshake. It applies standard SHA-256 padding: a 0x80 marker, zero fill, and a 64-bit bit-length. It presents each complete 512-bit block as one held word array, and the compression core loads it into its 16-word message store.

---
 rtl/sha256_pkg.sv | 16 +
 rtl/sha256_msg_padder_if.sv | 29 ++
 rtl/sha256_last_word_fmt.sv | 29 ++
 rtl/sha256_msg_padder.sv | 144 ++++++++++++++
 tb/tb_sha256_msg_padder.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared state encoding and block geometry for the SHA-256 message padder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sha256_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        EMIT = 2'd2
    } sha256_state_e;

    localparam int          SHA256_BLK_WORDS  = 16;
    localparam int          SHA256_LEN_IDX    = 14;
    localparam logic [31:0] SHA256_PAD_MARKER = 32'h8000_0000;

endpackage

// File: rtl/sha256_msg_padder_if.sv
// sha256_msg_padder_if: word stream in, padded 512-bit block out.
// Latency: none (wiring only).
// Backpressure: in_valid/in_ready on the word side, blk_valid/blk_ready on the block side.
interface sha256_msg_padder_if;

    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [1:0]   in_nbytes;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_first;
    logic         blk_last;

    // Message source and block consumer side.
    modport master (
        output in_data, in_valid, in_last, in_nbytes, blk_ready,
        input  in_ready, blk_data, blk_valid, blk_first, blk_last
    );

    // Padder side.
    modport slave (
        input  in_data, in_valid, in_last, in_nbytes, blk_ready,
        output in_ready, blk_data, blk_valid, blk_first, blk_last
    );

endinterface

// File: rtl/sha256_last_word_fmt.sv
// sha256_last_word_fmt: masks the final message word to its valid bytes and inserts the 0x80 marker.
// Latency: combinational.
// Backpressure: none; follows the word being accepted.
module sha256_last_word_fmt
    import sha256_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic        last,
    input  logic [1:0]  nbytes,
    output logic [31:0] word_out,
    output logic [2:0]  nbytes_eff
);

    // Keep bytes below the count, place the marker at the first unused byte, zero the rest.
    always_comb begin
        word_out   = word_in;
        nbytes_eff = 3'd4;
        if (last && (nbytes != 2'd0)) begin
            nbytes_eff = {1'b0, nbytes};
            for (int b = 0; b < 4; b++) begin
                if (b == int'(nbytes))
                    word_out[31-8*b -: 8] = SHA256_PAD_MARKER[31:24];
                else if (b > int'(nbytes))
                    word_out[31-8*b -: 8] = 8'h00;
            end
        end
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: packs big-endian message words into padded 512-bit SHA-256 blocks (SHA256_PAD_BYTE_EN honours in_nbytes).
// Latency: block valid the cycle after its 16th word is written; single-word message shows blk_valid 16 cycles after accept.
// Backpressure: in_ready low while padding or holding a block; block held stable until blk_ready.
module sha256_msg_padder
    import sha256_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    sha256_msg_padder_if.slave bus
);

    sha256_state_e state, state_nxt;

    logic [31:0] blk_buf [SHA256_BLK_WORDS];
    logic [4:0]  idx;
    logic [4:0]  idx_inc;
    logic [63:0] bitlen;
    logic        need_marker;
    logic        len_phase;
    logic        len_done;
    logic        first_flag;
    logic        msg_done;

    logic [31:0] word_fmt;
    logic [2:0]  word_nbytes;
    logic        accept;
    logic        emit_take;
    logic [31:0] pad_word;

    assign idx_inc       = idx + 5'd1;
    assign bus.blk_first = first_flag;
    assign bus.blk_last  = len_done;

`ifdef SHA256_PAD_BYTE_EN
    sha256_last_word_fmt u_fmt (
        .word_in    (bus.in_data),
        .last       (bus.in_last),
        .nbytes     (bus.in_nbytes),
        .word_out   (word_fmt),
        .nbytes_eff (word_nbytes)
    );
`else
    // Whole-word mode: every word is 4 bytes, so the marker always goes in its own word.
    logic [1:0] unused_nbytes;
    assign unused_nbytes = bus.in_nbytes;
    assign word_fmt      = bus.in_data;
    assign word_nbytes   = 3'd4;
`endif

    // Flatten the word buffer onto the block bus, word 0 in the top bits.
    always_comb begin
        bus.blk_data = '0;
        for (int i = 0; i < SHA256_BLK_WORDS; i++)
            bus.blk_data[511-32*i -: 32] = blk_buf[i];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    // Next state, handshakes and the padding word for the current index.
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.blk_valid = 1'b0;
        accept        = 1'b0;
        emit_take     = 1'b0;
        pad_word      = '0;
        case (state)
            FILL: begin
                bus.in_ready = !rst;
                accept       = bus.in_valid && !rst;
                if (accept) begin
                    if (idx_inc == 5'(SHA256_BLK_WORDS)) state_nxt = EMIT;
                    else if (bus.in_last)                state_nxt = PAD;
                end
            end
            PAD: begin
                if (need_marker)
                    pad_word = SHA256_PAD_MARKER;
                else if (idx == 5'(SHA256_LEN_IDX))
                    pad_word = bitlen[63:32];
                else if ((idx == 5'(SHA256_LEN_IDX + 1)) && len_phase)
                    pad_word = bitlen[31:0];
                if (idx_inc == 5'(SHA256_BLK_WORDS)) state_nxt = EMIT;
            end
            EMIT: begin
                bus.blk_valid = !rst;
                emit_take     = bus.blk_ready && !rst;
                if (emit_take) state_nxt = (!len_done && msg_done) ? PAD : FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    // Block buffer, write index, running bit length and padding flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SHA256_BLK_WORDS; i++) blk_buf[i] <= '0;
            idx         <= '0;
            bitlen      <= '0;
            need_marker <= 1'b0;
            len_phase   <= 1'b0;
            len_done    <= 1'b0;
            msg_done    <= 1'b0;
            first_flag  <= 1'b1;
        end else begin
            if (accept) begin
                blk_buf[idx[3:0]] <= word_fmt;
                idx               <= idx_inc;
                bitlen            <= bitlen + {58'd0, word_nbytes, 3'b000};
                if (bus.in_last) begin
                    msg_done <= 1'b1;
                    if (word_nbytes == 3'd4) need_marker <= 1'b1;
                end
            end
            if (state == PAD) begin
                blk_buf[idx[3:0]] <= pad_word;
                idx               <= idx_inc;
                if (need_marker)
                    need_marker <= 1'b0;
                else if (idx == 5'(SHA256_LEN_IDX))
                    len_phase <= 1'b1;
                else if ((idx == 5'(SHA256_LEN_IDX + 1)) && len_phase)
                    len_done <= 1'b1;
            end
            if (emit_take) begin
                idx        <= '0;
                first_flag <= 1'b0;
                if (len_done) begin
                    need_marker <= 1'b0;
                    len_phase   <= 1'b0;
                    len_done    <= 1'b0;
                    msg_done    <= 1'b0;
                    bitlen      <= '0;
                    first_flag  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: drives messages into sha256_msg_padder and checks blocks against a byte-level padding model.
// Latency: n/a (testbench).
// Backpressure: blk_ready held, released or randomised per scenario.
module tb_sha256_msg_padder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sha256_msg_padder_if bus ();

    sha256_msg_padder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          nwords;
        int          nb;
        int          exp_nblk;
        logic [31:0] exp_len_lo;
    } vec_t;

    int tests = 0;
    int fails = 0;

    logic [511:0] got_q [$];
    logic         got_first_q [$];
    logic         got_last_q [$];
    logic [511:0] exp_q [$];
    logic         exp_first_q [$];
    logic         exp_last_q [$];
    logic [31:0]  msg_w [$];

    bit   ready_rand = 1'b0;
    logic ready_val  = 1'b1;

    vec_t         vecs [8];
    int           base;
    int           n;
    logic [511:0] hold;
    logic [511:0] g;

    // Block consumer ready: held value or random stalls, changed just after each rising edge.
    initial begin
        bus.blk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_rand) bus.blk_ready = ($urandom_range(0, 2) != 0);
            else            bus.blk_ready = ready_val;
        end
    end

    // Record every block handed over (handshake completes at the next rising edge).
    always @(negedge clk) begin
        if (!rst && bus.blk_valid && bus.blk_ready) begin
            got_q.push_back(bus.blk_data);
            got_first_q.push_back(bus.blk_first);
            got_last_q.push_back(bus.blk_last);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk512(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [511:0] blk, input int i);
        return blk[511-32*i -: 32];
    endfunction

    task automatic send_word(input logic [31:0] d, input logic l, input logic [1:0] nb);
        int t;
        t = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.in_nbytes = nb;
        while (!bus.in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", t);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic fill_rand(input int nwords);
        msg_w.delete();
        for (int i = 0; i < nwords; i++) msg_w.push_back($urandom());
    endtask

    // Reference: message as a byte string, append 0x80, zero-pad to 56 mod 64, append 64-bit length.
    task automatic build_model(input int nb);
        byte unsigned    bq [$];
        logic [31:0]     w;
        logic [511:0]    blk;
        longint unsigned nbits;
        int              k;
        int              k_last;
        int              nblk;
        k_last = nb;
`ifndef SHA256_PAD_BYTE_EN
        k_last = 4;
`endif
        exp_q.delete();
        exp_first_q.delete();
        exp_last_q.delete();
        for (int i = 0; i < msg_w.size(); i++) begin
            w = msg_w[i];
            k = (i == msg_w.size() - 1) ? k_last : 4;
            for (int j = 0; j < k; j++) bq.push_back(w[31-8*j -: 8]);
        end
        nbits = 64'(bq.size()) * 64'd8;
        bq.push_back(8'h80);
        while ((bq.size() % 64) != 56) bq.push_back(8'h00);
        for (int j = 7; j >= 0; j--) bq.push_back(8'(nbits >> (8 * j)));
        nblk = bq.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = bq[b*64 + j];
            exp_q.push_back(blk);
            exp_first_q.push_back(b == 0);
            exp_last_q.push_back(b == nblk - 1);
        end
    endtask

    task automatic run_msg(input int nb, input bit gaps, output int base_o);
        int t;
        build_model(nb);
        base_o = got_q.size();
        for (int i = 0; i < msg_w.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
            if (i == msg_w.size() - 1) send_word(msg_w[i], 1'b1, 2'(nb));
            else                       send_word(msg_w[i], 1'b0, 2'($urandom_range(0, 3)));
        end
        t = 0;
        while (got_q.size() < base_o + exp_q.size() && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk32("blk_count", 32'(got_q.size() - base_o), 32'(exp_q.size()));
        for (int b = 0; b < exp_q.size(); b++) begin
            if (base_o + b < got_q.size()) begin
                chk512($sformatf("blk%0d_data", b), got_q[base_o + b], exp_q[b]);
                chk32($sformatf("blk%0d_first", b), 32'(got_first_q[base_o + b]), 32'(exp_first_q[b]));
                chk32($sformatf("blk%0d_last", b), 32'(got_last_q[base_o + b]), 32'(exp_last_q[b]));
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_nbytes = '0;

`ifdef SHA256_PAD_BYTE_EN
        vecs[0] = '{1,  3, 1, 32'h0000_0018};
        vecs[1] = '{13, 4, 1, 32'h0000_01A0};
        vecs[2] = '{14, 4, 2, 32'h0000_01C0};
        vecs[3] = '{16, 4, 2, 32'h0000_0200};
        vecs[4] = '{14, 3, 1, 32'h0000_01B8};
        vecs[5] = '{15, 2, 2, 32'h0000_01D0};
        vecs[6] = '{16, 1, 2, 32'h0000_01E8};
        vecs[7] = '{15, 4, 2, 32'h0000_01E0};
`else
        vecs[0] = '{1,  3, 1, 32'h0000_0020};
        vecs[1] = '{13, 4, 1, 32'h0000_01A0};
        vecs[2] = '{14, 4, 2, 32'h0000_01C0};
        vecs[3] = '{16, 4, 2, 32'h0000_0200};
        vecs[4] = '{14, 3, 2, 32'h0000_01C0};
        vecs[5] = '{15, 2, 2, 32'h0000_01E0};
        vecs[6] = '{16, 1, 2, 32'h0000_0200};
        vecs[7] = '{15, 4, 2, 32'h0000_01E0};
`endif

        // Reset state.
        repeat (3) @(negedge clk);
        chk32("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk32("rst_blk_valid", 32'(bus.blk_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk32("idle_in_ready", 32'(bus.in_ready), 32'd1);
        chk32("idle_blk_valid", 32'(bus.blk_valid), 32'd0);
        chk32("idle_blk_first", 32'(bus.blk_first), 32'd1);
        chk32("idle_blk_last", 32'(bus.blk_last), 32'd0);
        chk512("idle_blk_data", bus.blk_data, 512'd0);

        // Single-word latency and a 5-cycle consumer stall.
        ready_rand = 1'b0;
        ready_val  = 1'b0;
        repeat (2) @(negedge clk);
        fill_rand(1);
        build_model(4);
        base = got_q.size();
        send_word(msg_w[0], 1'b1, 2'd0);
        chk32("pad_in_ready", 32'(bus.in_ready), 32'd0);
        n = 1;
        while (!bus.blk_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk32("latency", 32'(n), 32'd16);
        hold = bus.blk_data;
        chk512("stall_blk", hold, exp_q[0]);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk32("stall_valid", 32'(bus.blk_valid), 32'd1);
            chk512("stall_data", bus.blk_data, hold);
            chk32("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        chk32("stall_no_take", 32'(got_q.size() - base), 32'd0);
        ready_val = 1'b1;
        @(negedge clk);
        chk32("release_valid", 32'(bus.blk_valid), 32'd1);
        chk32("release_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk32("after_take_in_ready", 32'(bus.in_ready), 32'd1);
        chk32("after_take_valid", 32'(bus.blk_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk32("one_handshake", 32'(got_q.size() - base), 32'd1);

        // Table of message lengths around the marker/length boundaries.
        for (int v = 0; v < 8; v++) begin
            fill_rand(vecs[v].nwords);
            run_msg(vecs[v].nb, 1'b0, base);
            chk32($sformatf("tbl%0d_nblk", v), 32'(got_q.size() - base), 32'(vecs[v].exp_nblk));
            if (base + vecs[v].exp_nblk <= got_q.size())
                chk32($sformatf("tbl%0d_len_lo", v),
                      word_of(got_q[base + vecs[v].exp_nblk - 1], 15), vecs[v].exp_len_lo);
        end

        // 14 full words: marker fills word 14, length spills into a second block.
        fill_rand(14);
        run_msg(4, 1'b0, base);
        if (got_q.size() >= base + 2) begin
            chk32("w14_b1_w14", word_of(got_q[base], 14), 32'h8000_0000);
            chk32("w14_b1_w15", word_of(got_q[base], 15), 32'h0000_0000);
            chk32("w14_b1_last", 32'(got_last_q[base]), 32'd0);
            chk32("w14_b2_w0", word_of(got_q[base + 1], 0), 32'h0000_0000);
            chk32("w14_b2_w15", word_of(got_q[base + 1], 15), 32'h0000_01C0);
            chk32("w14_b2_first", 32'(got_first_q[base + 1]), 32'd0);
        end

        // Reset after 5 words: nothing emitted, then "abc" from scratch.
        base = got_q.size();
        for (int i = 0; i < 5; i++) send_word($urandom(), 1'b0, 2'd0);
        rst = 1'b1;
        @(negedge clk);
        chk32("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk32("midrst_no_block", 32'(got_q.size() - base), 32'd0);
        msg_w.delete();
        msg_w.push_back(32'h6162_6300);
        run_msg(3, 1'b0, base);
        if (got_q.size() > base) begin
            g = got_q[base];
`ifdef SHA256_PAD_BYTE_EN
            chk32("abc_w0", word_of(g, 0), 32'h6162_6380);
            chk32("abc_w1", word_of(g, 1), 32'h0000_0000);
            chk32("abc_w15", word_of(g, 15), 32'h0000_0018);
`else
            chk32("abc_w0", word_of(g, 0), 32'h6162_6300);
            chk32("abc_w1", word_of(g, 1), 32'h8000_0000);
            chk32("abc_w15", word_of(g, 15), 32'h0000_0020);
`endif
            chk32("abc_w14", word_of(g, 14), 32'h0000_0000);
            chk32("abc_first", 32'(got_first_q[base]), 32'd1);
            chk32("abc_last", 32'(got_last_q[base]), 32'd1);
        end

        // Random lengths, byte counts, input gaps and consumer stalls.
        ready_rand = 1'b1;
        for (int m = 0; m < 25; m++) begin
            fill_rand(int'($urandom_range(1, 40)));
            run_msg(int'($urandom_range(1, 4)), 1'b1, base);
        end
        ready_rand = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
